// File: rtl/poly_addsub_if.sv
// Dual-port BRAM bundle: four banks, each with an A and a B port.
// The master drives enables, write strobes, addresses and write data. The slave returns read data.
interface DPBRAMInterface #(
  parameter int unsigned DW = 14,
  parameter int unsigned AW = 4
);
  logic          en_a   [4];
  logic          we_a   [4];
  logic [AW-1:0] addr_a [4];
  logic [DW-1:0] di_a   [4];
  logic [DW-1:0] do_a   [4];
  logic          en_b   [4];
  logic          we_b   [4];
  logic [AW-1:0] addr_b [4];
  logic [DW-1:0] di_b   [4];
  logic [DW-1:0] do_b   [4];

  modport master (
    output en_a, we_a, addr_a, di_a, en_b, we_b, addr_b, di_b,
    input  do_a, do_b
  );

  modport slave (
    input  en_a, we_a, addr_a, di_a, en_b, we_b, addr_b, di_b,
    output do_a, do_b
  );
endinterface

// File: rtl/poly_addsub.sv
// Coefficient-wise modular add/subtract of two banked polynomials into a third bundle.
// Define POLY_ADDSUB_SUB_EN to enable subtraction, which is selected by op.
`ifndef N
`define N 16
`endif
`ifndef K
`define K 14
`endif
`ifndef Q
`define Q 12289
`endif

module poly_addsub #(
  parameter int unsigned N           = `N,
  parameter int unsigned K           = `K,
  parameter int unsigned Q           = `Q,
  parameter int unsigned BANKS       = 2,
  parameter int unsigned PIPE_STAGES = 0
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic op,
  DPBRAMInterface.master input_bram_1,
  DPBRAMInterface.master input_bram_2,
  DPBRAMInterface.master output_brams,
  output logic busy,
  output logic done
);
  localparam int unsigned AW = (N > 2) ? $clog2(N) : 1;
  localparam int unsigned B  = N / (2 * BANKS);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_PROC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]    r_state, w_next;
  logic          r_rd_en;
  logic [AW-1:0] r_rd_row;
  logic          r_vld [PIPE_STAGES+1];
  logic [AW-1:0] r_row [PIPE_STAGES+1];
  logic [AW-1:0] r_wr_cnt;
  logic          w_wr_fire;
  logic          w_start;

  assign w_start   = (r_state == S_IDLE) && start;
  assign w_wr_fire = r_vld[PIPE_STAGES];

  function automatic logic [K-1:0] mod_add(input logic [K-1:0] a, input logic [K-1:0] b);
    logic [K:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= (K+1)'(Q)) s = s - (K+1)'(Q);
    return s[K-1:0];
  endfunction

`ifdef POLY_ADDSUB_SUB_EN
  logic r_op;

  function automatic logic [K-1:0] mod_sub(input logic [K-1:0] a, input logic [K-1:0] b);
    logic [K:0] d;
    d = {1'b0, a} - {1'b0, b};
    if (a < b) d = d + (K+1)'(Q);
    return d[K-1:0];
  endfunction

  // Operation is frozen for the whole run at the accepted start.
  always_ff @(posedge clk) begin
    if (reset)        r_op <= 1'b0;
    else if (w_start) r_op <= op;
  end
`else
  logic w_op_unused;
  assign w_op_unused = op;
`endif

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_PROC;
      S_PROC:  if (w_wr_fire && (r_wr_cnt == AW'(B - 1))) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      r_state <= w_next;
      busy    <= (w_next != S_IDLE);
      done    <= (w_next == S_DONE);
    end
  end

  // Read sequencer: one batch row per cycle, starting the cycle after start.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_en  <= 1'b0;
      r_rd_row <= '0;
    end else if (w_start) begin
      r_rd_en  <= 1'b1;
      r_rd_row <= '0;
    end else if (r_rd_en) begin
      if (r_rd_row == AW'(B - 1)) r_rd_en  <= 1'b0;
      else                        r_rd_row <= r_rd_row + AW'(1);
    end
  end

  // Stage 0 lines up with BRAM read data. The later stages track the result registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i <= PIPE_STAGES; i++) begin
        r_vld[i] <= 1'b0;
        r_row[i] <= '0;
      end
    end else begin
      r_vld[0] <= r_rd_en;
      r_row[0] <= r_rd_row;
      for (int i = 1; i <= PIPE_STAGES; i++) begin
        r_vld[i] <= r_vld[i-1];
        r_row[i] <= r_row[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset || (r_state == S_IDLE)) r_wr_cnt <= '0;
    else if (w_wr_fire)               r_wr_cnt <= r_wr_cnt + AW'(1);
  end

  for (genvar g = 0; g < 4; g++) begin : g_bank
    if (g < BANKS) begin : g_act
      logic [K-1:0] w_res_a, w_res_b, w_out_a, w_out_b;

`ifdef POLY_ADDSUB_SUB_EN
      assign w_res_a = r_op ? mod_sub(input_bram_1.do_a[g], input_bram_2.do_a[g])
                            : mod_add(input_bram_1.do_a[g], input_bram_2.do_a[g]);
      assign w_res_b = r_op ? mod_sub(input_bram_1.do_b[g], input_bram_2.do_b[g])
                            : mod_add(input_bram_1.do_b[g], input_bram_2.do_b[g]);
`else
      assign w_res_a = mod_add(input_bram_1.do_a[g], input_bram_2.do_a[g]);
      assign w_res_b = mod_add(input_bram_1.do_b[g], input_bram_2.do_b[g]);
`endif

      // With no result stages, write data comes straight from the BRAM read port.
      if (PIPE_STAGES == 0) begin : g_nopipe
        assign w_out_a = w_res_a;
        assign w_out_b = w_res_b;
      end else begin : g_pipe
        logic [K-1:0] r_da [PIPE_STAGES];
        logic [K-1:0] r_db [PIPE_STAGES];
        always_ff @(posedge clk) begin
          r_da[0] <= w_res_a;
          r_db[0] <= w_res_b;
          for (int i = 1; i < PIPE_STAGES; i++) begin
            r_da[i] <= r_da[i-1];
            r_db[i] <= r_db[i-1];
          end
        end
        assign w_out_a = r_da[PIPE_STAGES-1];
        assign w_out_b = r_db[PIPE_STAGES-1];
      end

      assign input_bram_1.en_a[g]   = r_rd_en;
      assign input_bram_1.we_a[g]   = 1'b0;
      assign input_bram_1.addr_a[g] = AW'({r_rd_row, 1'b0});
      assign input_bram_1.di_a[g]   = '0;
      assign input_bram_1.en_b[g]   = r_rd_en;
      assign input_bram_1.we_b[g]   = 1'b0;
      assign input_bram_1.addr_b[g] = AW'({r_rd_row, 1'b1});
      assign input_bram_1.di_b[g]   = '0;
      assign input_bram_2.en_a[g]   = r_rd_en;
      assign input_bram_2.we_a[g]   = 1'b0;
      assign input_bram_2.addr_a[g] = AW'({r_rd_row, 1'b0});
      assign input_bram_2.di_a[g]   = '0;
      assign input_bram_2.en_b[g]   = r_rd_en;
      assign input_bram_2.we_b[g]   = 1'b0;
      assign input_bram_2.addr_b[g] = AW'({r_rd_row, 1'b1});
      assign input_bram_2.di_b[g]   = '0;
      assign output_brams.en_a[g]   = w_wr_fire;
      assign output_brams.we_a[g]   = w_wr_fire;
      assign output_brams.addr_a[g] = AW'({r_row[PIPE_STAGES], 1'b0});
      assign output_brams.di_a[g]   = w_out_a;
      assign output_brams.en_b[g]   = w_wr_fire;
      assign output_brams.we_b[g]   = w_wr_fire;
      assign output_brams.addr_b[g] = AW'({r_row[PIPE_STAGES], 1'b1});
      assign output_brams.di_b[g]   = w_out_b;
    end else begin : g_off
      assign input_bram_1.en_a[g]   = 1'b0;
      assign input_bram_1.we_a[g]   = 1'b0;
      assign input_bram_1.addr_a[g] = '0;
      assign input_bram_1.di_a[g]   = '0;
      assign input_bram_1.en_b[g]   = 1'b0;
      assign input_bram_1.we_b[g]   = 1'b0;
      assign input_bram_1.addr_b[g] = '0;
      assign input_bram_1.di_b[g]   = '0;
      assign input_bram_2.en_a[g]   = 1'b0;
      assign input_bram_2.we_a[g]   = 1'b0;
      assign input_bram_2.addr_a[g] = '0;
      assign input_bram_2.di_a[g]   = '0;
      assign input_bram_2.en_b[g]   = 1'b0;
      assign input_bram_2.we_b[g]   = 1'b0;
      assign input_bram_2.addr_b[g] = '0;
      assign input_bram_2.di_b[g]   = '0;
      assign output_brams.en_a[g]   = 1'b0;
      assign output_brams.we_a[g]   = 1'b0;
      assign output_brams.addr_a[g] = '0;
      assign output_brams.di_a[g]   = '0;
      assign output_brams.en_b[g]   = 1'b0;
      assign output_brams.we_b[g]   = 1'b0;
      assign output_brams.addr_b[g] = '0;
      assign output_brams.di_b[g]   = '0;
    end
  end
endmodule

// File: tb/tb_poly_addsub.sv
// Directed bench for poly_addsub with two instances: BANKS=2/PIPE=0 and BANKS=4/PIPE=2.
// BRAMs are modelled in the bench. Coefficient c lives in bank c%BANKS at address c/BANKS.
module tb_poly_addsub;
  localparam int unsigned N = 16, K = 14, Q = 12289, AW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, start0, start1, op;
  logic busy0, done0, busy1, done1;

  DPBRAMInterface #(.DW(K), .AW(AW)) ia0 (), ib0 (), ob0 (), ia1 (), ib1 (), ob1 ();

  poly_addsub #(.N(N), .K(K), .Q(Q), .BANKS(2), .PIPE_STAGES(0)) dut0 (
    .clk(clk), .reset(reset), .start(start0), .op(op),
    .input_bram_1(ia0), .input_bram_2(ib0), .output_brams(ob0),
    .busy(busy0), .done(done0));

  poly_addsub #(.N(N), .K(K), .Q(Q), .BANKS(4), .PIPE_STAGES(2)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .op(op),
    .input_bram_1(ia1), .input_bram_2(ib1), .output_brams(ob1),
    .busy(busy1), .done(done1));

  logic [K-1:0] m0a [4][16], m0b [4][16], m0o [4][16];
  logic [K-1:0] m1a [4][16], m1b [4][16], m1o [4][16];

  always @(posedge clk) begin
    for (int g = 0; g < 4; g++) begin
      if (ia0.en_a[g]) ia0.do_a[g] <= m0a[g][ia0.addr_a[g]];
      if (ia0.en_b[g]) ia0.do_b[g] <= m0a[g][ia0.addr_b[g]];
      if (ib0.en_a[g]) ib0.do_a[g] <= m0b[g][ib0.addr_a[g]];
      if (ib0.en_b[g]) ib0.do_b[g] <= m0b[g][ib0.addr_b[g]];
      if (ob0.en_a[g] && ob0.we_a[g]) m0o[g][ob0.addr_a[g]] <= ob0.di_a[g];
      if (ob0.en_b[g] && ob0.we_b[g]) m0o[g][ob0.addr_b[g]] <= ob0.di_b[g];
      if (ia1.en_a[g]) ia1.do_a[g] <= m1a[g][ia1.addr_a[g]];
      if (ia1.en_b[g]) ia1.do_b[g] <= m1a[g][ia1.addr_b[g]];
      if (ib1.en_a[g]) ib1.do_a[g] <= m1b[g][ib1.addr_a[g]];
      if (ib1.en_b[g]) ib1.do_b[g] <= m1b[g][ib1.addr_b[g]];
      if (ob1.en_a[g] && ob1.we_a[g]) m1o[g][ob1.addr_a[g]] <= ob1.di_a[g];
      if (ob1.en_b[g] && ob1.we_b[g]) m1o[g][ob1.addr_b[g]] <= ob1.di_b[g];
    end
  end

  logic [7:0] w0_wr, w1_wr;
  logic       w0_rd, w1_rd, w0_act, w1_act, w0_hi;

  always_comb begin
    w0_wr = '0; w1_wr = '0; w0_rd = 1'b0; w1_rd = 1'b0;
    w0_act = 1'b0; w1_act = 1'b0; w0_hi = 1'b0;
    for (int g = 0; g < 4; g++) begin
      w0_wr[g]   = ob0.en_a[g] & ob0.we_a[g];
      w0_wr[g+4] = ob0.en_b[g] & ob0.we_b[g];
      w1_wr[g]   = ob1.en_a[g] & ob1.we_a[g];
      w1_wr[g+4] = ob1.en_b[g] & ob1.we_b[g];
      w0_rd = w0_rd | ia0.en_a[g] | ia0.en_b[g] | ib0.en_a[g] | ib0.en_b[g];
      w1_rd = w1_rd | ia1.en_a[g] | ia1.en_b[g] | ib1.en_a[g] | ib1.en_b[g];
      w0_act = w0_act | ia0.en_a[g] | ia0.en_b[g] | ib0.en_a[g] | ib0.en_b[g]
             | ob0.en_a[g] | ob0.en_b[g] | ob0.we_a[g] | ob0.we_b[g]
             | ia0.we_a[g] | ia0.we_b[g] | ib0.we_a[g] | ib0.we_b[g];
      w1_act = w1_act | ia1.en_a[g] | ia1.en_b[g] | ib1.en_a[g] | ib1.en_b[g]
             | ob1.en_a[g] | ob1.en_b[g] | ob1.we_a[g] | ob1.we_b[g]
             | ia1.we_a[g] | ia1.we_b[g] | ib1.we_a[g] | ib1.we_b[g];
    end
    for (int g = 2; g < 4; g++) begin
      w0_hi = w0_hi | ia0.en_a[g] | ia0.we_a[g] | (|ia0.addr_a[g]) | (|ia0.di_a[g])
                    | ia0.en_b[g] | ia0.we_b[g] | (|ia0.addr_b[g]) | (|ia0.di_b[g])
                    | ib0.en_a[g] | ib0.we_a[g] | (|ib0.addr_a[g]) | (|ib0.di_a[g])
                    | ib0.en_b[g] | ib0.we_b[g] | (|ib0.addr_b[g]) | (|ib0.di_b[g])
                    | ob0.en_a[g] | ob0.we_a[g] | (|ob0.addr_a[g]) | (|ob0.di_a[g])
                    | ob0.en_b[g] | ob0.we_b[g] | (|ob0.addr_b[g]) | (|ob0.di_b[g]);
    end
  end

  int n_cmp = 0, n_fail = 0;
  int av [16], bv [16];
  logic [7:0] wr_h [32];
  logic rd_h [32], act_h [32], busy_h [32];
  int done_first, done_cnt;
  logic hi_seen;

  task automatic load(input int d);
    for (int g = 0; g < 4; g++)
      for (int a = 0; a < 16; a++) begin
        m0o[g][a] = 14'h3FFF;
        m1o[g][a] = 14'h3FFF;
      end
    for (int c = 0; c < 16; c++) begin
      if (d == 0) begin
        m0a[c%2][c/2] = K'(av[c]);
        m0b[c%2][c/2] = K'(bv[c]);
      end else begin
        m1a[c%4][c/4] = K'(av[c]);
        m1b[c%4][c/4] = K'(bv[c]);
      end
    end
  endtask

  function automatic int out_val(input int d, input int c);
    return (d == 0) ? int'(m0o[c%2][c/2]) : int'(m1o[c%4][c/4]);
  endfunction

  // Cycle 0 is the start-sample cycle. Each cycle is observed on the falling edge.
  task automatic run(input int d, input logic opv, input int ncyc,
                     input int s2a, input int s2b, input int rst_at);
    done_first = -1; done_cnt = 0; hi_seen = 1'b0;
    for (int cyc = 0; cyc < ncyc; cyc++) begin
      start0 = (d == 0) && (cyc == 0 || cyc == s2a || cyc == s2b);
      start1 = (d == 1) && (cyc == 0 || cyc == s2a || cyc == s2b);
      op     = (cyc == 0) ? opv : ~opv;
      reset  = (cyc == rst_at);
      @(negedge clk);
      wr_h[cyc]   = (d == 0) ? w0_wr  : w1_wr;
      rd_h[cyc]   = (d == 0) ? w0_rd  : w1_rd;
      act_h[cyc]  = (d == 0) ? w0_act : w1_act;
      busy_h[cyc] = (d == 0) ? busy0  : busy1;
      hi_seen = hi_seen | w0_hi;
      if ((d == 0) ? done0 : done1) begin
        if (done_first < 0) done_first = cyc;
        done_cnt++;
      end
      @(posedge clk); #1;
    end
    start0 = 1'b0; start1 = 1'b0; reset = 1'b0; op = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; start0 = 1'b0; start1 = 1'b0; op = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (busy0 !== 1'b0) begin n_fail++; $display("FAIL reset_busy0 got %b want 0", busy0); end
    n_cmp++; if (done0 !== 1'b0) begin n_fail++; $display("FAIL reset_done0 got %b want 0", done0); end
    n_cmp++; if (w0_act !== 1'b0) begin n_fail++; $display("FAIL reset_en0 got %b want 0", w0_act); end
    n_cmp++; if (busy1 !== 1'b0) begin n_fail++; $display("FAIL reset_busy1 got %b want 0", busy1); end
    n_cmp++; if (w1_act !== 1'b0) begin n_fail++; $display("FAIL reset_en1 got %b want 0", w1_act); end
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_add_basic();
    for (int c = 0; c < 16; c++) begin av[c] = c; bv[c] = 100; end
    load(0);
    run(0, 1'b0, 10, -1, -1, -1);
    n_cmp++; if (done_first !== 6) begin n_fail++; $display("FAIL basic_done_cycle got %0d want 6", done_first); end
    n_cmp++; if (done_cnt !== 1) begin n_fail++; $display("FAIL basic_done_count got %0d want 1", done_cnt); end
    n_cmp++; if (hi_seen !== 1'b0) begin n_fail++; $display("FAIL basic_idle_banks got %b want 0", hi_seen); end
    for (int cyc = 0; cyc < 10; cyc++) begin
      logic [7:0] ew;
      logic er, eb;
      ew = (cyc >= 2 && cyc <= 5) ? 8'h33 : 8'h00;
      er = (cyc >= 1 && cyc <= 4);
      eb = (cyc >= 1 && cyc <= 6);
      n_cmp++; if (wr_h[cyc] !== ew) begin n_fail++; $display("FAIL basic_wr[%0d] got %h want %h", cyc, wr_h[cyc], ew); end
      n_cmp++; if (rd_h[cyc] !== er) begin n_fail++; $display("FAIL basic_rd[%0d] got %b want %b", cyc, rd_h[cyc], er); end
      n_cmp++; if (busy_h[cyc] !== eb) begin n_fail++; $display("FAIL basic_busy[%0d] got %b want %b", cyc, busy_h[cyc], eb); end
    end
    for (int c = 0; c < 16; c++) begin
      n_cmp++; if (out_val(0, c) !== c + 100) begin n_fail++; $display("FAIL basic_out[%0d] got %0d want %0d", c, out_val(0, c), c + 100); end
    end
  endtask

  task automatic test_add_wrap();
    for (int c = 0; c < 16; c++) begin av[c] = 12288; bv[c] = 5; end
    load(0);
    run(0, 1'b0, 9, -1, -1, -1);
    n_cmp++; if (done_first !== 6) begin n_fail++; $display("FAIL wrap_done_cycle got %0d want 6", done_first); end
    for (int c = 0; c < 16; c++) begin
      n_cmp++; if (out_val(0, c) !== 4) begin n_fail++; $display("FAIL wrap_out[%0d] got %0d want 4", c, out_val(0, c)); end
    end
  endtask

  task automatic test_add_boundary();
    int ta [8], tbv [8], te [8];
    ta  = '{12000, 12288, 16383, 12288,     1,     2, 12288, 7};
    tbv = '{  289, 12288, 16383,     0, 12287, 12287,     1, 9};
    te  = '{    0, 12287,  4093, 12288, 12288,     0,     0, 16};
    for (int c = 0; c < 16; c++) begin av[c] = ta[c%8]; bv[c] = tbv[c%8]; end
    load(0);
    run(0, 1'b0, 9, -1, -1, -1);
    for (int c = 0; c < 16; c++) begin
      n_cmp++; if (out_val(0, c) !== te[c%8]) begin n_fail++; $display("FAIL bound_out[%0d] got %0d want %0d", c, out_val(0, c), te[c%8]); end
    end
  endtask

  task automatic test_op_sub();
`ifdef POLY_ADDSUB_SUB_EN
    for (int c = 0; c < 16; c++) begin av[c] = 3; bv[c] = 10; end
    load(0);
    run(0, 1'b1, 9, -1, -1, -1);
    for (int c = 0; c < 16; c++) begin
      n_cmp++; if (out_val(0, c) !== 12282) begin n_fail++; $display("FAIL sub_neg_out[%0d] got %0d want 12282", c, out_val(0, c)); end
    end
    for (int c = 0; c < 16; c++) begin av[c] = 10; bv[c] = 3; end
    load(0);
    run(0, 1'b1, 9, -1, -1, -1);
    for (int c = 0; c < 16; c++) begin
      n_cmp++; if (out_val(0, c) !== 7) begin n_fail++; $display("FAIL sub_pos_out[%0d] got %0d want 7", c, out_val(0, c)); end
    end
`else
    for (int c = 0; c < 16; c++) begin av[c] = 3; bv[c] = 10; end
    load(0);
    run(0, 1'b1, 9, -1, -1, -1);
    for (int c = 0; c < 16; c++) begin
      n_cmp++; if (out_val(0, c) !== 13) begin n_fail++; $display("FAIL op_ignored_out[%0d] got %0d want 13", c, out_val(0, c)); end
    end
`endif
  endtask

  task automatic test_pipe();
    for (int c = 0; c < 16; c++) begin av[c] = c; bv[c] = 100; end
    load(1);
    run(1, 1'b0, 10, -1, -1, -1);
    n_cmp++; if (done_first !== 6) begin n_fail++; $display("FAIL pipe_done_cycle got %0d want 6", done_first); end
    n_cmp++; if (done_cnt !== 1) begin n_fail++; $display("FAIL pipe_done_count got %0d want 1", done_cnt); end
    for (int cyc = 0; cyc < 10; cyc++) begin
      logic [7:0] ew;
      logic er;
      ew = (cyc == 4 || cyc == 5) ? 8'hFF : 8'h00;
      er = (cyc == 1 || cyc == 2);
      n_cmp++; if (wr_h[cyc] !== ew) begin n_fail++; $display("FAIL pipe_wr[%0d] got %h want %h", cyc, wr_h[cyc], ew); end
      n_cmp++; if (rd_h[cyc] !== er) begin n_fail++; $display("FAIL pipe_rd[%0d] got %b want %b", cyc, rd_h[cyc], er); end
    end
    for (int c = 0; c < 16; c++) begin
      n_cmp++; if (out_val(1, c) !== c + 100) begin n_fail++; $display("FAIL pipe_out[%0d] got %0d want %0d", c, out_val(1, c), c + 100); end
    end
  endtask

  task automatic test_reset_mid();
    for (int c = 0; c < 16; c++) begin av[c] = c; bv[c] = 1; end
    load(0);
    run(0, 1'b0, 10, -1, -1, 3);
    n_cmp++; if (act_h[3] !== 1'b1) begin n_fail++; $display("FAIL rstmid_active3 got %b want 1", act_h[3]); end
    n_cmp++; if (busy_h[4] !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy4 got %b want 0", busy_h[4]); end
    n_cmp++; if (done_cnt !== 0) begin n_fail++; $display("FAIL rstmid_done_count got %0d want 0", done_cnt); end
    for (int cyc = 4; cyc < 10; cyc++) begin
      n_cmp++; if (act_h[cyc] !== 1'b0) begin n_fail++; $display("FAIL rstmid_en[%0d] got %b want 0", cyc, act_h[cyc]); end
    end
  endtask

  task automatic test_start_ignored();
    for (int c = 0; c < 16; c++) begin av[c] = c; bv[c] = 2; end
    load(0);
    run(0, 1'b0, 12, 2, 6, -1);
    n_cmp++; if (done_cnt !== 1) begin n_fail++; $display("FAIL ign_done_count got %0d want 1", done_cnt); end
    n_cmp++; if (done_first !== 6) begin n_fail++; $display("FAIL ign_done_cycle got %0d want 6", done_first); end
    n_cmp++; if (busy_h[7] !== 1'b0) begin n_fail++; $display("FAIL ign_busy7 got %b want 0", busy_h[7]); end
    n_cmp++; if (busy_h[8] !== 1'b0) begin n_fail++; $display("FAIL ign_busy8 got %b want 0", busy_h[8]); end
    for (int cyc = 6; cyc < 12; cyc++) begin
      n_cmp++; if (act_h[cyc] !== 1'b0) begin n_fail++; $display("FAIL ign_en[%0d] got %b want 0", cyc, act_h[cyc]); end
    end
    for (int c = 0; c < 16; c++) begin
      n_cmp++; if (out_val(0, c) !== c + 2) begin n_fail++; $display("FAIL ign_out[%0d] got %0d want %0d", c, out_val(0, c), c + 2); end
    end
  endtask

  initial begin
    test_reset();
    test_add_basic();
    test_add_wrap();
    test_add_boundary();
    test_op_sub();
    test_pipe();
    test_reset_mid();
    test_start_ignored();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
